// File: rtl/ts_pkg.sv
// ts_pkg: shared types and constants for the transport-stream sync framer.
// State enum, packet/sync constants and the packet position counter width.
package ts_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCK
    } ts_state_t;

    localparam int         TS_PKT_LEN   = 204;
    localparam logic [7:0] TS_SYNC      = 8'h47;
    localparam logic [7:0] TS_INV_SYNC  = 8'hB8;
    localparam int         TS_GROUP_LEN = 8;
    localparam int         TS_POS_W     = $clog2(TS_PKT_LEN);

endpackage

// File: rtl/byte_reg_slice.sv
// byte_reg_slice: one-entry 8-bit rdy/acpt output register, no skid buffer.
// Ports: in_load/in_data (write), in_acpt (room), out_rdy/out_data/out_acpt.
module byte_reg_slice (
    input  logic       clock1,
    input  logic       reset_n,
    input  logic       in_load,
    input  logic [7:0] in_data,
    output logic       in_acpt,
    output logic       out_rdy,
    output logic [7:0] out_data,
    input  logic       out_acpt
);

    // Room exists when empty or when the held byte leaves this cycle.
    assign in_acpt = !out_rdy | out_acpt;

    always_ff @(posedge clock1 or negedge reset_n) begin
        if (!reset_n) begin
            out_rdy  <= 1'b0;
            out_data <= 8'h00;
        end else if (in_load) begin
            out_rdy  <= 1'b1;
            out_data <= in_data;
        end else if (out_acpt) begin
            out_rdy  <= 1'b0;
        end
    end

endmodule

// File: rtl/ts_sync_framer.sv
// ts_sync_framer: acquires/tracks 0x47 packet sync, regenerates sync bytes
// (0xB8 on first packet of each group) and forwards whole locked packets.
// Ports: clock1, reset_n, di_rdy/di_acpt/di_data in, do_rdy/do_acpt/do_data
// out, locked, sync_err_cnt (saturating missed syncs while locked).
module ts_sync_framer
    import ts_pkg::*;
#(
    parameter int         PKT_LEN    = TS_PKT_LEN,
    parameter int         GROUP_LEN  = TS_GROUP_LEN,
    parameter int         LOCK_CNT   = 3,
    parameter int         UNLOCK_CNT = 3,
    parameter logic [7:0] SYNC_BYTE  = TS_SYNC,
    parameter logic [7:0] INV_SYNC   = TS_INV_SYNC
) (
    input  logic        clock1,
    input  logic        reset_n,
    input  logic        di_rdy,
    output logic        di_acpt,
    input  logic [7:0]  di_data,
    output logic        do_rdy,
    input  logic        do_acpt,
    output logic [7:0]  do_data,
    output logic        locked,
    output logic [15:0] sync_err_cnt
);

    localparam int PW = $clog2(PKT_LEN);
    localparam int GW = $clog2(GROUP_LEN);
    localparam int MC = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CW = $clog2(MC + 1);

    ts_state_t     state, state_n;
    logic [PW-1:0] pos, pos_n;
    logic [GW-1:0] grp, grp_n;
    logic [CW-1:0] good, good_n;
    logic [CW-1:0] miss, miss_n;
    logic [15:0]   err, err_n;

    logic          xfer;
    logic          fwd;
    logic [7:0]    fwd_data;
    logic          is_sync;
    logic          at_sof;
    logic [PW-1:0] pos_inc;
    logic [GW-1:0] grp_inc;
    logic [CW-1:0] good_inc;
    logic [CW-1:0] miss_inc;

    assign xfer     = di_rdy & di_acpt;
    assign is_sync  = (di_data == SYNC_BYTE);
    assign at_sof   = (pos == '0);
    assign pos_inc  = (pos == PW'(PKT_LEN - 1)) ? '0 : pos + 1'b1;
    assign grp_inc  = (grp == GW'(GROUP_LEN - 1)) ? '0 : grp + 1'b1;
    assign good_inc = good + 1'b1;
    assign miss_inc = miss + 1'b1;

    always_ff @(posedge clock1 or negedge reset_n) begin
        if (!reset_n) begin
            state <= HUNT;
            pos   <= '0;
            grp   <= '0;
            good  <= '0;
            miss  <= '0;
            err   <= '0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            grp   <= grp_n;
            good  <= good_n;
            miss  <= miss_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        grp_n    = grp;
        good_n   = good;
        miss_n   = miss;
        err_n    = err;
        fwd      = 1'b0;
        fwd_data = di_data;
        if (xfer) begin
            pos_n = pos_inc;
            unique case (state)
                HUNT: begin
                    pos_n = '0;
                    if (is_sync) begin
                        state_n = VERIFY;
                        pos_n   = PW'(1);
                        good_n  = CW'(1);
                    end
                end
                VERIFY: begin
                    if (at_sof) begin
                        if (!is_sync) begin
                            state_n = HUNT;
                            pos_n   = '0;
                            good_n  = '0;
                        end else if (good_inc == CW'(LOCK_CNT)) begin
                            // The confirming sync opens the first group.
                            state_n  = LOCK;
                            good_n   = '0;
                            grp_n    = GW'(1);
                            miss_n   = '0;
                            fwd      = 1'b1;
                            fwd_data = INV_SYNC;
                        end else begin
                            good_n = good_inc;
                        end
                    end
                end
                LOCK: begin
                    fwd = 1'b1;
                    if (at_sof) begin
                        // Sync is rebuilt from grp, never copied from input.
                        fwd_data = (grp == '0) ? INV_SYNC : SYNC_BYTE;
                        grp_n    = grp_inc;
                        if (is_sync) begin
                            miss_n = '0;
                        end else begin
                            miss_n = miss_inc;
                            if (err != 16'hFFFF)
                                err_n = err + 16'd1;
                            if (miss_inc == CW'(UNLOCK_CNT)) begin
                                // Drop this sync so output ends on a packet edge.
                                state_n = HUNT;
                                pos_n   = '0;
                                miss_n  = '0;
                                fwd     = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    pos_n   = '0;
                end
            endcase
        end
    end

    byte_reg_slice u_out (
        .clock1   (clock1),
        .reset_n  (reset_n),
        .in_load  (xfer & fwd),
        .in_data  (fwd_data),
        .in_acpt  (di_acpt),
        .out_rdy  (do_rdy),
        .out_data (do_data),
        .out_acpt (do_acpt)
    );

    assign locked       = (state == LOCK);
    assign sync_err_cnt = err;

endmodule

// File: tb/tb_ts_sync_framer.sv
// tb_ts_sync_framer: randomized stream with handshake jitter, checked against
// a byte-level behavioural model of sync acquisition/tracking.
module tb_ts_sync_framer;

    localparam int PKT = 204;

    logic        clock1 = 1'b0;
    logic        reset_n = 1'b0;
    logic        di_rdy = 1'b0;
    logic        di_acpt;
    logic [7:0]  di_data = 8'h00;
    logic        do_rdy;
    logic        do_acpt = 1'b0;
    logic [7:0]  do_data;
    logic        locked;
    logic [15:0] sync_err_cnt;

    ts_sync_framer dut (
        .clock1       (clock1),
        .reset_n      (reset_n),
        .di_rdy       (di_rdy),
        .di_acpt      (di_acpt),
        .di_data      (di_data),
        .do_rdy       (do_rdy),
        .do_acpt      (do_acpt),
        .do_data      (do_data),
        .locked       (locked),
        .sync_err_cnt (sync_err_cnt)
    );

    always #5 clock1 = ~clock1;

    int checks = 0;
    int errors = 0;

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];

    // Behavioural view: 0 hunting, 1 verifying, 2 locked.
    int m_mode, m_pos, m_good, m_miss, m_grp, m_err;
    int n_out, cyc;
    bit first_seen;
    logic [7:0] last_out;
    bit p_rdy, p_acpt;
    logic [7:0] p_data;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0;
        m_grp = 0; m_err = 0;
        exp_q.delete();
        p_rdy = 0; p_acpt = 0; p_data = 8'h00;
    endtask

    // One accepted input byte, applied to the sync rules.
    task automatic model_byte(input logic [7:0] b);
        bit sof;
        sof = (m_pos == 0);
        if (m_mode == 0) begin
            if (b == 8'h47) begin
                m_mode = 1; m_pos = 1; m_good = 1;
            end
            return;
        end
        m_pos = (m_pos + 1) % PKT;
        if (m_mode == 1) begin
            if (!sof) return;
            if (b != 8'h47) begin
                m_mode = 0; m_pos = 0;
            end else if (++m_good == 3) begin
                m_mode = 2; m_grp = 1; m_miss = 0;
                exp_q.push_back(8'hB8);
            end
            return;
        end
        if (!sof) begin
            exp_q.push_back(b);
            return;
        end
        if (b == 8'h47) begin
            m_miss = 0;
        end else begin
            m_miss++;
            if (m_err < 65535) m_err++;
        end
        if (m_miss == 3) begin
            m_mode = 0; m_pos = 0; m_miss = 0;
            return;
        end
        exp_q.push_back(m_grp == 0 ? 8'hB8 : 8'h47);
        m_grp = (m_grp + 1) % 8;
    endtask

    function automatic logic [7:0] rnd_byte(input bit no47);
        logic [7:0] b;
        b = 8'($urandom);
        if (no47 && b == 8'h47) b = 8'h46;
        return b;
    endfunction

    task automatic add_pkt(input logic [7:0] sync, input bit no47);
        in_q.push_back(sync);
        repeat (PKT - 1) in_q.push_back(rnd_byte(no47));
    endtask

    task automatic step(input bit feed, input bit acpt1, input bit stall);
        logic [7:0] e;
        @(negedge clock1);
        di_rdy  = feed && (in_q.size() > 0) && ($urandom_range(0, 4) != 0);
        di_data = di_rdy ? in_q[0] : 8'($urandom);
        do_acpt = stall ? 1'b0 : (acpt1 ? 1'b1 : ($urandom_range(0, 3) != 0));
        #1;
        cyc++;
        chk("locked", locked, (m_mode == 2));
        chk("sync_err_cnt", sync_err_cnt, m_err);
        chk("di_acpt", di_acpt, (!do_rdy | do_acpt));
        if (stall && do_rdy) chk("stall_acpt", di_acpt, 0);
        if (p_rdy && !p_acpt) begin
            chk("hold_rdy", do_rdy, 1);
            chk("hold_data", do_data, p_data);
        end
        if (do_rdy && do_acpt) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", do_rdy, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", do_data, e);
                if (!first_seen) chk("first_out", do_data, 8'hB8);
                first_seen = 1;
                last_out = do_data;
                n_out++;
            end
        end
        if (di_rdy && di_acpt) begin
            void'(in_q.pop_front());
            model_byte(di_data);
        end
        p_rdy  = do_rdy;
        p_acpt = do_acpt;
        p_data = do_data;
    endtask

    task automatic run_stream(input bit drain);
        int guard;
        guard = 0;
        while (in_q.size() > 0 && guard < 20000) begin
            step(1, 0, (cyc >= 1500 && cyc < 1510));
            guard++;
        end
        if (in_q.size() > 0) chk("timeout", in_q.size(), 0);
        if (drain) repeat (6) step(0, 1, 0);
    endtask

    logic [7:0] exp_last;
    int out_before;

    initial begin
        model_reset();
        n_out = 0; cyc = 0; first_seen = 0; last_out = 8'h00;
        repeat (3) @(negedge clock1);
        reset_n = 1'b1;
        repeat (3) @(negedge clock1);
        #1;
        chk("rst_do_rdy", do_rdy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", sync_err_cnt, 0);
        chk("rst_di_acpt", di_acpt, 1);

        // Acquisition and group inversion: 14 clean packets.
        repeat (5) in_q.push_back(8'h00);
        repeat (14) add_pkt(8'h47, 0);
        run_stream(1);
        chk("acq_locked", locked, 1);
        chk("acq_count", n_out, 12 * PKT);

        // Single corrupted sync while locked.
        add_pkt(8'h00, 0);
        repeat (2) add_pkt(8'h47, 0);
        run_stream(1);
        chk("miss1_err", sync_err_cnt, 1);
        chk("miss1_locked", locked, 1);

        // Three consecutive corrupted syncs.
        add_pkt(8'h00, 1);
        add_pkt(8'h00, 1);
        exp_last = in_q[in_q.size() - 1];
        add_pkt(8'h00, 1);
        run_stream(1);
        chk("unlock_locked", locked, 0);
        chk("unlock_err", sync_err_cnt, 4);
        chk("unlock_last", last_out, exp_last);

        // False sync in HUNT.
        out_before = n_out;
        in_q.push_back(8'h47);
        repeat (PKT - 1) in_q.push_back(rnd_byte(1));
        in_q.push_back(8'h11);
        repeat (10) in_q.push_back(rnd_byte(1));
        run_stream(1);
        chk("false_locked", locked, 0);
        chk("false_no_out", n_out, out_before);

        // Relock, then reset mid-packet with a byte pending.
        repeat (4) add_pkt(8'h47, 0);
        repeat (50) in_q.push_back(rnd_byte(0));
        run_stream(0);
        @(negedge clock1);
        di_rdy = 1'b1;
        di_data = 8'h5A;
        do_acpt = 1'b0;
        @(negedge clock1);
        #1;
        chk("pre_rst_locked", locked, 1);
        chk("pre_rst_rdy", do_rdy, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rdy", do_rdy, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_err", sync_err_cnt, 0);
        chk("mid_rst_acpt", di_acpt, 1);
        di_rdy = 1'b0;
        @(negedge clock1);
        reset_n = 1'b1;
        model_reset();
        in_q.delete();
        repeat (2) step(0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
